core_boot_sequencer: RTL

CORE_BOOT_SEQUENCER -- requirements
Module: core_boot_sequencer

---
 rtl/core_boot_sequencer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_boot_sequencer.sv
// Core boot sequencer: initialises data memory from an image, then streams
// INSTR/REG/BAR/PC packets to each core in turn, then monitors the cores'
// PASS/FAIL/DONE stores until every core has finished.

package core_boot_pkg;
  typedef enum logic [2:0] {
    OP_NULL  = 3'd0,
    OP_INSTR = 3'd1,
    OP_REG   = 3'd2,
    OP_BAR   = 3'd3,
    OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;        // one-hot destination core
    logic [3:0]  reserved;
    net_op_e     net_op;
    logic [9:0]  net_addr;
    logic [31:0] net_data;
  } net_packet_s;
endpackage

module core_boot_sequencer
  import core_boot_pkg::*;
#(
  parameter int          NUM_CORES_P   = 4,
  parameter int          INSTR_DEPTH_P = 1024,
  parameter int          DATA_DEPTH_P  = 1024,
  parameter int          REG_COUNT_P   = 64,
  parameter logic [31:0] BAR_MASK_P    = 32'h2,
  parameter logic [31:0] START_PC_P    = 32'h5,
  localparam int MAXD_P = ((INSTR_DEPTH_P > DATA_DEPTH_P) ? INSTR_DEPTH_P : DATA_DEPTH_P) > REG_COUNT_P
                          ? ((INSTR_DEPTH_P > DATA_DEPTH_P) ? INSTR_DEPTH_P : DATA_DEPTH_P) : REG_COUNT_P,
  localparam int AW = (MAXD_P > 1) ? $clog2(MAXD_P) : 1,
  localparam int CW = (NUM_CORES_P > 1) ? $clog2(NUM_CORES_P) : 1
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic [1:0]                       img_sel_o,
  output logic [AW-1:0]                    img_addr_o,
  input  logic [39:0]                      img_data_i,
  output logic                             mem_wen_o,
  output logic [31:0]                      mem_addr_o,
  output logic [31:0]                      mem_wdata_o,
  output logic                             pkt_valid_o,
  input  logic                             pkt_ready_i,
  output logic [$bits(net_packet_s)-1:0]   pkt_o,
  input  logic [NUM_CORES_P-1:0]           mon_valid_i,
  input  logic [32*NUM_CORES_P-1:0]        mon_addr_i,
  output logic                             done_o,
  output logic                             fail_o,
  output logic [CW-1:0]                    fail_core_o,
  output logic [8*NUM_CORES_P-1:0]         pass_count_o,
  output logic [31:0]                      cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_INIT, S_INSTR, S_REG, S_BAR, S_PC, S_RUN, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [AW-1:0]                 idx_q, idx_d;
  logic [CW-1:0]                 core_q, core_d;
  logic                          fail_q, fail_d;
  logic [CW-1:0]                 fail_core_q, fail_core_d;
  logic [NUM_CORES_P-1:0]        fin_q, fin_d;
  logic [NUM_CORES_P-1:0][7:0]   pass_q, pass_d;
  logic [31:0]                   cyc_q, cyc_d;

  logic [NUM_CORES_P-1:0][31:0]  mon_addr;
  logic [NUM_CORES_P-1:0]        mon_bad, mon_good, mon_pass;
  net_packet_s                   pkt;
  logic                          pkt_fire;
  logic                          unused_img_bits;

  assign mon_addr        = mon_addr_i;
  assign unused_img_bits = ^img_data_i[39:38];
  assign pkt_fire        = pkt_valid_o && pkt_ready_i;

  // Classify each core's store address into fail / finished / pass events.
  always_comb begin
    mon_bad  = '0;
    mon_good = '0;
    mon_pass = '0;
    for (int c = 0; c < NUM_CORES_P; c++) begin
      mon_bad[c]  = mon_valid_i[c] && (mon_addr[c] == 32'hDEAD_DEAD);
      mon_good[c] = mon_valid_i[c] && (mon_addr[c] == 32'h600D_BEEF);
      mon_pass[c] = mon_valid_i[c] && (mon_addr[c] == 32'hC0FF_EEEE);
    end
  end

  // Image read, memory write and packet formation for the current state.
  always_comb begin
    pkt         = '0;
    pkt_valid_o = 1'b0;
    img_sel_o   = 2'd0;
    img_addr_o  = '0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_MEM_INIT: begin
        img_addr_o  = idx_q;
        mem_wen_o   = 1'b1;
        mem_addr_o  = 32'(idx_q) << 2;
        mem_wdata_o = img_data_i[31:0];
      end
      S_INSTR: begin
        img_sel_o    = 2'd1;
        img_addr_o   = idx_q;
        pkt_valid_o  = 1'b1;
        pkt.id       = 10'd1 << core_q;
        pkt.net_op   = OP_INSTR;
        pkt.net_addr = 10'(idx_q);
        pkt.net_data = {16'h0, img_data_i[15:0]};
      end
      S_REG: begin
        img_sel_o    = 2'd2;
        img_addr_o   = idx_q;
        pkt_valid_o  = 1'b1;
        pkt.id       = 10'd1 << core_q;
        pkt.net_op   = OP_REG;
        pkt.net_addr = {4'h0, img_data_i[37:32]};
        pkt.net_data = img_data_i[31:0];
      end
      S_BAR: begin
        pkt_valid_o  = 1'b1;
        pkt.id       = 10'd1 << core_q;
        pkt.net_op   = OP_BAR;
        pkt.net_addr = 10'd24;
        pkt.net_data = BAR_MASK_P;
      end
      S_PC: begin
        pkt_valid_o  = 1'b1;
        pkt.id       = 10'd1 << core_q;
        pkt.net_op   = OP_PC;
        pkt.net_addr = 10'd0;
        pkt.net_data = START_PC_P;
      end
      default: ;
    endcase
  end

  assign pkt_o = pkt;

  // Sequencing, per-core finish tracking and RUN-phase counters.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    core_d      = core_q;
    fail_d      = fail_q;
    fail_core_d = fail_core_q;
    fin_d       = fin_q;
    pass_d      = pass_q;
    cyc_d       = cyc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_MEM_INIT;
          idx_d       = '0;
          core_d      = '0;
          fail_d      = 1'b0;
          fail_core_d = '0;
          fin_d       = '0;
          pass_d      = '0;
          cyc_d       = '0;
        end
      end
      S_MEM_INIT: begin
        if (idx_q == AW'(DATA_DEPTH_P - 1)) begin
          state_d = S_INSTR;
          idx_d   = '0;
          core_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_INSTR: begin
        if (pkt_fire) begin
          if (idx_q == AW'(INSTR_DEPTH_P - 1)) begin
            state_d = S_REG;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_REG: begin
        if (pkt_fire) begin
          if (idx_q == AW'(REG_COUNT_P - 1)) begin
            state_d = S_BAR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_BAR: begin
        if (pkt_fire) state_d = S_PC;
      end
      S_PC: begin
        if (pkt_fire) begin
          if (core_q == CW'(NUM_CORES_P - 1)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_INSTR;
            core_d  = core_q + 1'b1;
            idx_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
        fin_d = fin_q | mon_bad | mon_good;
        for (int c = 0; c < NUM_CORES_P; c++) begin
          if (mon_pass[c] && (pass_q[c] != 8'hFF)) pass_d[c] = pass_q[c] + 8'd1;
        end
        // Only the first failing cycle records a core; lowest index wins ties.
        if (!fail_q && (|mon_bad)) begin
          fail_d = 1'b1;
          for (int c = NUM_CORES_P - 1; c >= 0; c--) begin
            if (mon_bad[c]) fail_core_d = CW'(c);
          end
        end
        if (&fin_d) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      core_q      <= '0;
      fail_q      <= 1'b0;
      fail_core_q <= '0;
      fin_q       <= '0;
      pass_q      <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      core_q      <= core_d;
      fail_q      <= fail_d;
      fail_core_q <= fail_core_d;
      fin_q       <= fin_d;
      pass_q      <= pass_d;
      cyc_q       <= cyc_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign fail_o        = fail_q;
  assign fail_core_o   = fail_core_q;
  assign pass_count_o  = pass_q;
  assign cycle_count_o = cyc_q;

endmodule
